// File: rtl/triangle_fetch_if.sv
// Pipelined Avalon-style read bus between triangle_fetch (master) and vertex memory (slave).
// Responses return in request order; waitrequest stalls the request phase only.
interface triangle_fetch_if #(
  parameter int ADDR_W = 32
) ();
  logic              mem_read;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_waitrequest;
  logic [31:0]       mem_readdata;
  logic              mem_readdatavalid;

  modport master (
    output mem_read,
    output mem_address,
    input  mem_waitrequest,
    input  mem_readdata,
    input  mem_readdatavalid
  );

  modport slave (
    input  mem_read,
    input  mem_address,
    output mem_waitrequest,
    output mem_readdata,
    output mem_readdatavalid
  );
endinterface

// File: rtl/triangle_fetch.sv
// Walks a list of packed 15-word triangle records and presents each one as a vertex
// bundle to the transform stage, one triangle in flight at a time.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for start; stray read responses are dropped
// S_FETCH   | issuing 15 reads for the current record, capturing responses
// S_PRESENT | bundle valid, held until the consumer takes it (!stall_in)
module triangle_fetch #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  tri_count,
  output logic              busy,
  triangle_fetch_if.master  mem,
  output logic [14:0][31:0] v_out,
  output logic [23:0]       color_out1,
  output logic [23:0]       color_out2,
  output logic [23:0]       color_out3,
  output logic              out_data_valid,
  output logic              done_out,
  input  logic              stall_in
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_PRESENT = 2'd2
  } state_t;

  localparam logic [3:0] LAST_WORD = 4'd14;

  state_t            state;
  logic [ADDR_W-1:0] rec_base;
  logic [CNT_W-1:0]  remaining;
  logic [3:0]        issue_cnt;
  logic [3:0]        recv_cnt;

  logic [ADDR_W-1:0] base_aligned;
  logic [ADDR_W-1:0] next_base;
  logic              req_accepted;

  assign base_aligned = base_addr & ~ADDR_W'(3);
  assign next_base    = rec_base + ADDR_W'(60);
  assign req_accepted = mem.mem_read && !mem.mem_waitrequest;

  assign color_out1 = v_out[3][23:0];
  assign color_out2 = v_out[7][23:0];
  assign color_out3 = v_out[11][23:0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= S_IDLE;
      busy            <= 1'b0;
      mem.mem_read    <= 1'b0;
      mem.mem_address <= '0;
      rec_base        <= '0;
      remaining       <= '0;
      issue_cnt       <= '0;
      recv_cnt        <= '0;
      v_out           <= '0;
      out_data_valid  <= 1'b0;
      done_out        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && (tri_count != '0)) begin
            rec_base        <= base_aligned;
            mem.mem_address <= base_aligned;
            mem.mem_read    <= 1'b1;
            remaining       <= tri_count;
            issue_cnt       <= '0;
            recv_cnt        <= '0;
            busy            <= 1'b1;
            state           <= S_FETCH;
          end
        end

        S_FETCH: begin
          // Request and response sides advance independently; reads overlap responses.
          if (req_accepted) begin
            issue_cnt       <= issue_cnt + 4'd1;
            mem.mem_address <= mem.mem_address + ADDR_W'(4);
            if (issue_cnt == LAST_WORD) begin
              mem.mem_read <= 1'b0;
            end
          end
          if (mem.mem_readdatavalid) begin
            for (int k = 0; k < 15; k++) begin
              if (recv_cnt == 4'(k)) begin
                v_out[k] <= mem.mem_readdata;
              end
            end
            recv_cnt <= recv_cnt + 4'd1;
            if (recv_cnt == LAST_WORD) begin
              out_data_valid <= 1'b1;
              done_out       <= (remaining == CNT_W'(1));
              state          <= S_PRESENT;
            end
          end
        end

        S_PRESENT: begin
          if (!stall_in) begin
            out_data_valid <= 1'b0;
            done_out       <= 1'b0;
            if (remaining > CNT_W'(1)) begin
              remaining       <= remaining - CNT_W'(1);
              rec_base        <= next_base;
              mem.mem_address <= next_base;
              mem.mem_read    <= 1'b1;
              issue_cnt       <= '0;
              recv_cnt        <= '0;
              state           <= S_FETCH;
            end else begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  a_no_extra_rsp: assert property (@(posedge clock) disable iff (!reset)
    (state == S_FETCH && mem.mem_readdatavalid) |-> (recv_cnt != 4'd15));

  a_valid_in_present: assert property (@(posedge clock) disable iff (!reset)
    out_data_valid |-> (state == S_PRESENT));
`endif

endmodule

// File: tb/tb_triangle_fetch.sv
// Bench for triangle_fetch: memory responder, transaction-level expectation model
// (address stream and record queue) checked every cycle, plus directed literal checks.
module tb_triangle_fetch;

  logic              clock;
  logic              reset;
  logic              start;
  logic [31:0]       base_addr;
  logic [15:0]       tri_count;
  logic              busy;
  logic [14:0][31:0] v_out;
  logic [23:0]       color_out1, color_out2, color_out3;
  logic              out_data_valid;
  logic              done_out;
  logic              stall_in;

  triangle_fetch_if #(.ADDR_W(32)) bus ();

  triangle_fetch #(.ADDR_W(32), .CNT_W(16)) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .base_addr      (base_addr),
    .tri_count      (tri_count),
    .busy           (busy),
    .mem            (bus),
    .v_out          (v_out),
    .color_out1     (color_out1),
    .color_out2     (color_out2),
    .color_out3     (color_out3),
    .out_data_valid (out_data_valid),
    .done_out       (done_out),
    .stall_in       (stall_in)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory image: record r (relative to 0x1000) word k = k<<16 + r, rgb words 0x00AABBCC + r.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] off, k, rec;
    off = (a - 32'h1000) >> 2;
    k   = off % 15;
    rec = off / 15;
    if (k == 3 || k == 7 || k == 11) return 32'h00AABBCC + rec;
    return (k << 16) + rec;
  endfunction

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Memory slave; everything it drives changes on the falling edge.
  bit          wait_mode = 0;
  bit          gap_mode  = 0;
  int          stale_n   = 0;
  logic [31:0] mem_q[$];

  initial begin
    int cyc;
    cyc = 0;
    bus.mem_waitrequest   = 1'b0;
    bus.mem_readdata      = '0;
    bus.mem_readdatavalid = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        mem_q.delete();
        bus.mem_readdatavalid = 1'b0;
        bus.mem_waitrequest   = 1'b0;
      end else begin
        if (stale_n > 0) begin
          bus.mem_readdatavalid = 1'b1;
          bus.mem_readdata      = 32'hDEAD0000 + 32'(stale_n);
          stale_n--;
        end else if (mem_q.size() > 0 && (!gap_mode || $urandom_range(0, 2) != 0)) begin
          bus.mem_readdatavalid = 1'b1;
          bus.mem_readdata      = mem_word(mem_q.pop_front());
        end else begin
          bus.mem_readdatavalid = 1'b0;
        end
        cyc++;
        bus.mem_waitrequest = wait_mode ? (cyc % 3 != 0) : 1'b0;
        if (bus.mem_read && !bus.mem_waitrequest) mem_q.push_back(bus.mem_address);
      end
    end
  end

  // Expectation model: pending request addresses and pending record bases.
  logic [31:0] exp_addr[$];
  logic [31:0] exp_rec[$];
  bit          m_busy = 0;
  int          edge_n = 0;
  int          start_edge = 0;
  int          first_valid_edge = -1;
  int          acc_count = 0;
  int          rsp_count = 0;
  logic [31:0] first_acc_addr = '0;
  logic [31:0] last_acc_addr  = '0;

  initial begin
    logic        s_start, s_read, s_wr, s_rdv, s_odv, s_stall, s_rst;
    logic [31:0] s_base, s_addr, rb;
    logic [15:0] s_cnt;
    forever begin
      @(posedge clock);
      edge_n++;
      s_rst   = !reset;
      s_start = start;
      s_base  = base_addr;
      s_cnt   = tri_count;
      s_read  = bus.mem_read;
      s_addr  = bus.mem_address;
      s_wr    = bus.mem_waitrequest;
      s_rdv   = bus.mem_readdatavalid;
      s_odv   = out_data_valid;
      s_stall = stall_in;
      if (s_rst) begin
        exp_addr.delete();
        exp_rec.delete();
        m_busy = 0;
      end else begin
        if (s_start && !m_busy && s_cnt != 0) begin
          m_busy     = 1;
          start_edge = edge_n;
          for (int t = 0; t < int'(s_cnt); t++) begin
            rb = (s_base & ~32'h3) + 32'(60 * t);
            exp_rec.push_back(rb);
            for (int i = 0; i < 15; i++) exp_addr.push_back(rb + 32'(4 * i));
          end
        end else begin
          if (s_read && !s_wr) begin
            if (acc_count == 0) first_acc_addr = s_addr;
            last_acc_addr = s_addr;
            acc_count++;
            if (exp_addr.size() == 0) check("unexpected_request", s_addr, 32'hFFFF_FFFF);
            else check("req_addr", s_addr, exp_addr.pop_front());
          end
          if (s_rdv && m_busy) rsp_count++;
          if (s_odv && !s_stall && exp_rec.size() > 0) begin
            void'(exp_rec.pop_front());
            if (exp_rec.size() == 0) begin
              m_busy = 0;
              check("addr_stream_drained", 32'(exp_addr.size()), 32'd0);
            end
          end
        end
      end
      #1;
      if (s_rst) begin
        check("reset_ctrl", {28'd0, busy, bus.mem_read, out_data_valid, done_out}, 32'd0);
        check("reset_addr", bus.mem_address, 32'd0);
        check("reset_vout", 32'(|v_out), 32'd0);
      end else begin
        check("busy", 32'(busy), 32'(m_busy));
        if (!m_busy) check("idle_no_read", 32'(bus.mem_read), 32'd0);
        if (out_data_valid) begin
          if (first_valid_edge < 0) first_valid_edge = edge_n;
          check("read_while_valid", 32'(bus.mem_read), 32'd0);
          if (exp_rec.size() == 0) begin
            check("unexpected_valid", 32'(out_data_valid), 32'd0);
          end else begin
            for (int k = 0; k < 15; k++)
              check($sformatf("v_out[%0d]", k), v_out[k], mem_word(exp_rec[0] + 32'(4 * k)));
            check("color_out1", 32'(color_out1), mem_word(exp_rec[0] + 32'd12) & 32'h00FF_FFFF);
            check("color_out2", 32'(color_out2), mem_word(exp_rec[0] + 32'd28) & 32'h00FF_FFFF);
            check("color_out3", 32'(color_out3), mem_word(exp_rec[0] + 32'd44) & 32'h00FF_FFFF);
            check("done_out", 32'(done_out), 32'(exp_rec.size() == 1));
          end
        end else begin
          check("done_without_valid", 32'(done_out), 32'd0);
        end
      end
    end
  end

  task automatic pulse_start(input logic [31:0] b, input logic [15:0] c);
    @(negedge clock);
    base_addr = b;
    tri_count = c;
    start     = 1'b1;
    @(negedge clock);
    start     = 1'b0;
  endtask

  task automatic wait_valid(input int max, input string name);
    int n;
    n = 0;
    @(negedge clock);
    while (!out_data_valid && n < max) begin
      @(negedge clock);
      n++;
    end
    check(name, 32'(out_data_valid), 32'd1);
  endtask

  task automatic wait_idle(input int max, input string name);
    int n;
    n = 0;
    @(negedge clock);
    while (busy && n < max) begin
      @(negedge clock);
      n++;
    end
    check(name, 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [14:0][31:0] snap;
  int n;

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    tri_count = '0;
    stall_in  = 1'b0;
    repeat (3) @(negedge clock);
    #2 reset = 1'b1;
    repeat (2) @(negedge clock);

    // Single triangle, zero-wait memory.
    acc_count = 0;
    first_valid_edge = -1;
    pulse_start(32'h1000, 16'd1);
    wait_valid(100, "t1_valid_timeout");
    check("t1_latency", 32'(first_valid_edge - start_edge + 1), 32'd17);
    check("t1_v_out5", v_out[5], 32'h0005_0000);
    check("t1_color1", 32'(color_out1), 32'h00AA_BBCC);
    check("t1_done", 32'(done_out), 32'd1);
    check("t1_first_addr", first_acc_addr, 32'h1000);
    check("t1_last_addr", last_acc_addr, 32'h1038);
    check("t1_req_count", 32'(acc_count), 32'd15);
    @(negedge clock);
    check("t1_busy_fell", 32'(busy), 32'd0);

    // Two triangles, consumer stalls the first bundle.
    acc_count = 0;
    stall_in  = 1'b1;
    pulse_start(32'h1000, 16'd2);
    wait_valid(100, "t2_valid1_timeout");
    snap = v_out;
    check("t2_done1", 32'(done_out), 32'd0);
    check("t2_req_count1", 32'(acc_count), 32'd15);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("t2_stall_hold", 32'(v_out == snap), 32'd1);
      check("t2_stall_no_read", 32'(bus.mem_read), 32'd0);
      check("t2_stall_done", 32'(done_out), 32'd0);
    end
    acc_count = 0;
    stall_in  = 1'b0;
    wait_valid(100, "t2_valid2_timeout");
    check("t2_first_addr2", first_acc_addr, 32'h103C);
    check("t2_done2", 32'(done_out), 32'd1);
    check("t2_v_out0", v_out[0], 32'h0000_0001);
    check("t2_color1", 32'(color_out1), 32'h00AA_BBCD);
    wait_idle(20, "t2_idle_timeout");

    // Waitrequest 2 of 3 cycles, gapped responses.
    wait_mode = 1;
    gap_mode  = 1;
    acc_count = 0;
    pulse_start(32'h1078, 16'd1);
    wait_valid(400, "t3_valid_timeout");
    check("t3_req_count", 32'(acc_count), 32'd15);
    check("t3_v_out14", v_out[14], 32'h000E_0002);
    wait_idle(20, "t3_idle_timeout");
    wait_mode = 0;
    gap_mode  = 0;
    repeat (3) @(negedge clock);

    // Reset after 7 responses, then stale responses in IDLE.
    rsp_count = 0;
    pulse_start(32'h1000, 16'd2);
    n = 0;
    while (rsp_count < 7 && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("t4_reach_7_rsp", 32'(rsp_count), 32'd7);
    #2 reset = 1'b0;
    #1;
    check("t4_rst_busy", 32'(busy), 32'd0);
    check("t4_rst_read", 32'(bus.mem_read), 32'd0);
    check("t4_rst_addr", bus.mem_address, 32'd0);
    check("t4_rst_vout", 32'(|v_out), 32'd0);
    check("t4_rst_valid", 32'(out_data_valid), 32'd0);
    repeat (2) @(negedge clock);
    #2 reset = 1'b1;
    @(posedge clock);
    #3 stale_n = 3;
    repeat (6) @(negedge clock);
    check("t4_stale_vout", 32'(|v_out), 32'd0);
    check("t4_stale_busy", 32'(busy), 32'd0);
    check("t4_stale_valid", 32'(out_data_valid), 32'd0);
    acc_count = 0;
    pulse_start(32'h2000, 16'd1);
    wait_valid(100, "t4_valid_timeout");
    check("t4_first_addr", first_acc_addr, 32'h2000);
    wait_idle(20, "t4_idle_timeout");

    // Zero-length list.
    pulse_start(32'h1000, 16'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      check("t5_no_read", 32'(bus.mem_read), 32'd0);
      check("t5_no_busy", 32'(busy), 32'd0);
    end

    // start during FETCH is ignored.
    acc_count = 0;
    pulse_start(32'h1000, 16'd1);
    repeat (3) @(negedge clock);
    pulse_start(32'h5000, 16'd3);
    wait_valid(100, "t6_valid_timeout");
    check("t6_req_count", 32'(acc_count), 32'd15);
    check("t6_first_addr", first_acc_addr, 32'h1000);
    check("t6_done", 32'(done_out), 32'd1);
    wait_idle(20, "t6_idle_timeout");
    repeat (3) @(negedge clock);
    check("t6_stays_idle", 32'(busy), 32'd0);

    // Unaligned base is word-aligned.
    acc_count = 0;
    pulse_start(32'h1003, 16'd1);
    wait_valid(100, "t7_valid_timeout");
    check("t7_first_addr", first_acc_addr, 32'h1000);
    check("t7_v_out5", v_out[5], 32'h0005_0000);
    wait_idle(20, "t7_idle_timeout");
    repeat (2) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
